simon_ksa: RTL and testbench
============================

Name: simon_ksa

Overview:
- Single-step key-schedule unit for the Simon 32/64 block cipher.
- Given the current 4-word key window and a round index, it produces the next 16-bit round key.
- Sits beside the round datapath. The controller feeds it the sliding key window each round and shifts each result back into the window.
- Output is registered with one-cycle latency.

Parameters:
- SIZE, 16, word size in bits (round-key width); only 16 is supported.
- KEY_SIZE, 64, key-window width (4 x SIZE); only 64 is supported.
- ROUND_BITS, 5, width of the round index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe; round and key are sampled when high.
- round  input  ROUND_BITS  round index i, 0..31.
- key  input  KEY_SIZE  key window {k[i+3], k[i+2], k[i+1], k[i]}; key[15:0] = k[i], key[63:48] = k[i+3].
- new_key  output  SIZE  computed round key k[i+4].
- out_valid  output  1  high for one cycle when new_key holds a fresh result.

Behaviour:
- Reset: on a rising clk with reset=1, new_key <= 16'h0000 and out_valid <= 0. Reset has priority over in_valid. A request in flight during reset is discarded.
- Latency: when in_valid=1 at edge N, new_key and out_valid=1 are valid after edge N+1.
  - Back-to-back requests are accepted every cycle, fully pipelined with one stage.
  - No back-pressure.
- When in_valid=0: out_valid <= 0 and new_key holds its last value.
- Computation (all arithmetic is 16-bit XOR/rotate, no carries):
  - a = ROR(k[i+3], 3)
  - b = a XOR k[i+1]
  - c = b XOR ROR(b, 1)
  - new = k[i] XOR c XOR 16'hFFFC XOR {15'b0, z0[round]}
  - k[i+2] is unused.
- z0 constant: bit string indexed from 0 (leftmost = index 0): 11111010001001010110000111001101111101000100101011000011100110.
  - Only indices 0..31 are reachable. Implement as a 32-entry constant lookup; no wrap logic is needed.
- ROR(x, n) is a right rotate within 16 bits.
- All 32 round values are legal. Rounds 0..27 are used by Simon 32/64; 28..31 still produce the defined result.
- No internal key storage: each request is independent of prior requests.
- Inputs are assumed stable only at the sampling edge. No X-propagation handling is required beyond standard RTL semantics.

Test Plan:
- Reset behaviour:
  - Stimulus: assert reset for 3 cycles with in_valid=1 and arbitrary inputs.
  - Required response: new_key=0000 and out_valid=0 throughout. One cycle after release with in_valid=1, out_valid rises.
- Round 0:
  - Stimulus: round=0, key=64'h1918_1110_0908_0100, in_valid pulsed.
  - Required response: next cycle new_key=16'h71C3, out_valid=1. The following idle cycle gives out_valid=0 with new_key holding 71C3.
- Round 1 chained:
  - Stimulus: round=1, key=64'h71C3_1918_1110_0908.
  - Required response: new_key=16'hB649.
- Full expansion:
  - Stimulus: drive rounds 0..27 back-to-back, each cycle shifting the previous result into the window.
  - Required response: matches the Simon 32/64 schedule, continuing 56D4, E070, F15A, C535, ...
- z-bit sensitivity:
  - Stimulus: key=0 with round=4 (z=1), then round=5 (z=0).
  - Required response: new_key=16'hFFFD for round 4 and 16'hFFFC for round 5.
- Unused word and rotation:
  - Stimulus: key=64'h0000_FFFF_0000_0000 (only k[i+2] set), round=5.
  - Required response: 16'hFFFC.
  - Stimulus: key=64'h0008_0000_0000_0000, round=5.
  - Required response: FFFC XOR 0001 XOR 8000 = 16'h7FFD.

Source files
------------

// File: rtl/simon_ksa.sv
`default_nettype none
// ============================================================================
//  Module      : simon_ksa
//  Description : Single-step key-schedule unit for Simon 32/64. From the
//                current 4-word key window and a round index it produces
//                the next 16-bit round key, registered with one cycle of
//                latency. The unit is fully pipelined and accepts a new
//                request every cycle. It keeps no key state between
//                requests.
//
//  Ports
//    clk        : system clock, rising-edge active
//    reset      : synchronous, active-high reset
//    in_valid   : request strobe; round/key sampled when high
//    round      : round index i (0..31)
//    key        : key window {k[i+3], k[i+2], k[i+1], k[i]}
//    new_key    : computed round key k[i+4]
//    out_valid  : one-cycle pulse when new_key holds a fresh result
//
//  Revision    : 1.0  initial release
// ============================================================================
module simon_ksa #(
    parameter int SIZE       = 16,
    parameter int KEY_SIZE   = 64,
    parameter int ROUND_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [ROUND_BITS-1:0] round,
    input  logic [KEY_SIZE-1:0]   key,
    output logic [SIZE-1:0]       new_key,
    output logic                  out_valid
);

    // z0 sequence, first 32 bits. Bit n of this vector holds sequence
    // index n, where index 0 is the leftmost character of the published
    // bit string 1111101000100101 0110000111001101...
    localparam logic [31:0]     C_Z0    = 32'hB386_A45F;
    // Constant c = 2^SIZE - 4 folded into every round key.
    localparam logic [SIZE-1:0] C_ROUND = 16'hFFFC;

    // ------------------------------------------------------------------
    // Key window unpacking. k[i+2] does not participate in the 4-word
    // Simon schedule; it is reduced into a deliberately unused wire.
    // ------------------------------------------------------------------
    logic [SIZE-1:0] w_k0;
    logic [SIZE-1:0] w_k1;
    logic [SIZE-1:0] w_k3;
    logic            w_unused_k2;

    assign w_k0        = key[SIZE-1:0];
    assign w_k1        = key[2*SIZE-1:SIZE];
    assign w_k3        = key[4*SIZE-1:3*SIZE];
    assign w_unused_k2 = ^key[3*SIZE-1:2*SIZE];

    // ------------------------------------------------------------------
    // Round function: pure XOR / rotate network, no carries.
    //   a   = ROR(k3, 3)
    //   b   = a ^ k1
    //   c   = b ^ ROR(b, 1)
    //   new = k0 ^ c ^ C_ROUND ^ z0[round]
    // ------------------------------------------------------------------
    logic [SIZE-1:0] w_a;
    logic [SIZE-1:0] w_b;
    logic [SIZE-1:0] w_c;
    logic            w_z;
    logic [SIZE-1:0] w_new;

    assign w_a   = {w_k3[2:0], w_k3[SIZE-1:3]};
    assign w_b   = w_a ^ w_k1;
    assign w_c   = w_b ^ {w_b[0], w_b[SIZE-1:1]};
    assign w_z   = C_Z0[round];
    assign w_new = w_k0 ^ w_c ^ C_ROUND ^ {{(SIZE-1){1'b0}}, w_z};

    // ------------------------------------------------------------------
    // Output register. The result holds its last value while idle; the
    // valid flag simply follows the request strobe by one cycle.
    // ------------------------------------------------------------------
    logic [SIZE-1:0] new_key_q;
    logic [SIZE-1:0] new_key_d;
    logic            out_valid_q;
    logic            out_valid_d;

    always_comb begin
        new_key_d   = new_key_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            new_key_d = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            new_key_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            new_key_q   <= new_key_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign new_key   = new_key_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_ksa.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_ksa
//  Description : Self-checking bench for simon_ksa. Stimulus pushes the
//                expected round key into a scoreboard queue; an independent
//                monitor pops and compares whenever out_valid is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_simon_ksa;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  round;
    logic [63:0] key;
    logic [15:0] new_key;
    logic        out_valid;

    simon_ksa #(
        .SIZE       (16),
        .KEY_SIZE   (64),
        .ROUND_BITS (5)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .round     (round),
        .key       (key),
        .new_key   (new_key),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   next_id = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference round function written bit by bit from the cipher
    // definition; z0 comes straight from the published bit string.
    function automatic logic [15:0] ref_key(input logic [63:0] w, input int r);
        string       zs;
        logic [15:0] k0, k1, k3, a, b, c, res;
        zs = "11111010001001010110000111001101111101000100101011000011100110";
        k0 = w[15:0];
        k1 = w[31:16];
        k3 = w[63:48];
        for (int j = 0; j < 16; j++) a[j] = k3[(j + 3) % 16];
        b = a ^ k1;
        for (int j = 0; j < 16; j++) c[j] = b[j] ^ b[(j + 1) % 16];
        res = k0 ^ c ^ 16'hFFFC;
        if (zs[r] == 8'h31) res[0] = ~res[0];
        return res;
    endfunction

    // Drive one cycle of stimulus on the falling edge; a valid request
    // records its expected result in the scoreboard.
    task automatic drive(input logic v, input int r, input logic [63:0] k, input logic [15:0] exp);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        round    = r[4:0];
        key      = k;
        if (v) begin
            e.id  = next_id;
            e.exp = exp;
            next_id++;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: got key %h expected no output", new_key);
                end else begin
                    e = sb_q.pop_front();
                    check16($sformatf("vec%0d", e.id), new_key, e.exp);
                end
            end
        end
    end

    localparam logic [63:0] C_KEY = 64'h1918_1110_0908_0100;

    initial begin
        logic [63:0] w;
        logic [15:0] exp;
        logic [15:0] hand [6];
        hand = '{16'h71C3, 16'hB649, 16'h56D4, 16'hE070, 16'hF15A, 16'hC535};

        // Reset with a request held high: nothing may come out.
        reset    = 1'b1;
        in_valid = 1'b1;
        round    = 5'd7;
        key      = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("reset_out_valid", out_valid, 1'b0);
            check16("reset_new_key", new_key, 16'h0000);
        end

        // Release with a round-0 request, then one idle cycle.
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        round    = 5'd0;
        key      = C_KEY;
        sb_q.push_back('{id: next_id, exp: 16'h71C3});
        next_id++;
        drive(1'b0, 0, 64'h0, 16'h0);
        @(posedge clk);
        #1;
        check1("idle_out_valid", out_valid, 1'b0);
        check16("idle_hold_key", new_key, 16'h71C3);

        // Round 1, chained window.
        drive(1'b1, 1, 64'h71C3_1918_1110_0908, 16'hB649);
        drive(1'b0, 0, 64'h0, 16'h0);

        // Full expansion, back to back, shifting each result into the window.
        w = C_KEY;
        for (int r = 0; r < 28; r++) begin
            exp = (r < 6) ? hand[r] : ref_key(w, r);
            drive(1'b1, r, w, exp);
            w = {exp, w[63:16]};
        end

        // z-bit sensitivity, unused word, rotation.
        drive(1'b1, 4, 64'h0, 16'hFFFD);
        drive(1'b1, 5, 64'h0, 16'hFFFC);
        drive(1'b1, 5, 64'h0000_FFFF_0000_0000, 16'hFFFC);
        drive(1'b1, 5, 64'h0008_0000_0000_0000, 16'h7FFD);

        // Rounds beyond the cipher's 28 remain defined.
        for (int r = 28; r < 32; r++) begin
            drive(1'b1, r, 64'h0123_4567_89AB_CDEF, ref_key(64'h0123_4567_89AB_CDEF, r));
        end

        drive(1'b0, 0, 64'h0, 16'h0);
        @(posedge clk);
        #1;
        check1("final_idle_out_valid", out_valid, 1'b0);
        check16("final_hold_key", new_key, ref_key(64'h0123_4567_89AB_CDEF, 31));

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
